// File: rtl/fl_slr_pkg.sv
// Shared types and helpers for the FrameLink SLR-crossing receive buffer.
//
// Contents:
//   FL_DATA_WIDTH / FL_DREM_WIDTH  default FrameLink data and REM widths
//   fl_word_t                      one buffered FrameLink word; the top packs
//                                  its ports in this same bit order
//   rdy_threshold()                free-space level at or above which the
//                                  buffer keeps offering ready to the crossing
package fl_slr_pkg;

    localparam int FL_DATA_WIDTH = 64;
    localparam int FL_DREM_WIDTH = 3;

    typedef struct packed {
        logic                     sof_n;
        logic                     eof_n;
        logic                     sop_n;
        logic                     eop_n;
        logic [FL_DREM_WIDTH-1:0] rem;
        logic [FL_DATA_WIDTH-1:0] data;
    } fl_word_t;

    // Once ready drops, the crossing can still deliver up to 2*latency+1
    // words: latency stages for ready to get back, latency stages of data
    // already on their way, plus the word launched in the turnaround cycle.
    // One extra slot is kept as margin.
    function automatic int rdy_threshold(input int latency);
        return 2 * latency + 2;
    endfunction

endpackage

// File: rtl/fl_slr_rx_mem.sv
// Simple dual-port word store for the receive buffer.
//
// Ports:
//   clk, rst_n         clock; async active-low reset (read register only)
//   wr_en/addr/data    write port, one word per cycle
//   rd_en/addr         read request; data appears in rd_data after the edge
//   rd_data            registered read data, held while rd_en is low
//
// The array itself is never reset so it maps onto distributed RAM; only the
// read register is cleared. Reading the slot that is written in the same
// cycle returns the old contents.
module fl_slr_rx_mem #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fl_slr_rx_buffer.sv
// Receive-side elastic buffer placed after a FrameLink SLR crossing.
//
// Ports:
//   CLK, RESET_N               clock; asynchronous active-low reset
//   RX_*                       FrameLink words arriving from the crossing
//   RX_DST_RDY_N               registered ready returned to the crossing
//   TX_*                       re-emitted FrameLink stream
//   OVERFLOW                   sticky: a word arrived while the buffer was full
//
// Handshake: an RX word is taken whenever RX_SRC_RDY_N=0, whatever
// RX_DST_RDY_N shows (ready is a credit hint for the far side of the
// crossing). A TX word moves when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0 at the
// same rising edge; while not taken, every TX_* output holds.
//
// Datapath: memory -> registered read stage -> optional output register.
// count tracks words in memory only; words sitting in the read stage or the
// output register have already left the credit pool.
module fl_slr_rx_buffer
    import fl_slr_pkg::*;
#(
    parameter int DATA_WIDTH = FL_DATA_WIDTH,
    parameter int DREM_WIDTH = FL_DREM_WIDTH,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 8,
    parameter int USE_OUTREG = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [DREM_WIDTH-1:0] RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [DREM_WIDTH-1:0] TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_EOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    output logic                  OVERFLOW
);

    localparam int WORD_W = DATA_WIDTH + DREM_WIDTH + 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(rdy_threshold(LATENCY));

    logic [WORD_W-1:0] rx_word;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] tx_word;
    logic              tx_vld;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rx_dst_rdy_n_q, rx_dst_rdy_n_d;
    logic              overflow_q, overflow_d;
    logic              rd_vld_q, rd_vld_d;
    logic              out_vld_q, out_vld_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;

    logic              tx_take;
    logic              out_load;
    logic              rd_free;
    logic              mem_rd;
    logic              wr_ok;

    assign rx_word = {RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_REM, RX_DATA};

    fl_slr_rx_mem #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_word),
        .rd_en   (mem_rd),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    assign tx_word = (USE_OUTREG != 0) ? out_word_q : rd_word;
    assign tx_vld  = (USE_OUTREG != 0) ? out_vld_q  : rd_vld_q;

    always_comb begin
        tx_take        = tx_vld & ~TX_DST_RDY_N;
        out_load       = 1'b0;
        rd_free        = 1'b0;
        mem_rd         = 1'b0;
        wr_ok          = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        rx_dst_rdy_n_d = rx_dst_rdy_n_q;
        overflow_d     = overflow_q;
        rd_vld_d       = rd_vld_q;
        out_vld_d      = out_vld_q;
        out_word_d     = out_word_q;

        // The read stage may refill when it is empty or its word leaves this
        // cycle; with the output register that lets the pair act as a skid
        // and keep one word per cycle flowing across a stall release.
        if (USE_OUTREG != 0) begin
            out_load = rd_vld_q & (~out_vld_q | tx_take);
            rd_free  = ~rd_vld_q | out_load;
        end else begin
            rd_free  = ~rd_vld_q | tx_take;
        end

        mem_rd = (count_q != '0) & rd_free;
        // Full is judged from count; a read in the same cycle frees a slot.
        wr_ok  = ~RX_SRC_RDY_N & ((count_q != DEPTH_C) | mem_rd);

        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(mem_rd);
        count_d  = count_q + CW'(wr_ok) - CW'(mem_rd);

        rx_dst_rdy_n_d = ((DEPTH_C - count_d) < THRESH_C);
        overflow_d     = overflow_q | (~RX_SRC_RDY_N & ~wr_ok);

        if (mem_rd) begin
            rd_vld_d = 1'b1;
        end else if ((USE_OUTREG != 0) ? out_load : tx_take) begin
            rd_vld_d = 1'b0;
        end

        if (out_load) begin
            out_vld_d  = 1'b1;
            out_word_d = rd_word;
        end else if (tx_take) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rx_dst_rdy_n_q <= 1'b1;
            overflow_q     <= 1'b0;
            rd_vld_q       <= 1'b0;
            out_vld_q      <= 1'b0;
            out_word_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rx_dst_rdy_n_q <= rx_dst_rdy_n_d;
            overflow_q     <= overflow_d;
            rd_vld_q       <= rd_vld_d;
            out_vld_q      <= out_vld_d;
            out_word_q     <= out_word_d;
        end
    end

    assign {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_REM, TX_DATA} = tx_word;
    assign TX_SRC_RDY_N = ~tx_vld;
    assign RX_DST_RDY_N = rx_dst_rdy_n_q;
    assign OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_fl_slr_rx_buffer.sv
// Self-checking bench for fl_slr_rx_buffer (LATENCY=2, DEPTH=8, USE_OUTREG=1).
module tb_fl_slr_rx_buffer;
    import fl_slr_pkg::*;

    localparam int DW  = 64;
    localparam int RW  = 3;
    localparam int LAT = 2;
    localparam int DEP = 8;
    localparam int W   = DW + RW + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic RESET_N = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [DW-1:0] RX_DATA;
    logic [RW-1:0] RX_REM;
    logic          RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N;
    logic          RX_SRC_RDY_N;
    logic          RX_DST_RDY_N;
    logic [DW-1:0] TX_DATA;
    logic [RW-1:0] TX_REM;
    logic          TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
    logic          TX_SRC_RDY_N;
    logic          TX_DST_RDY_N;
    logic          OVERFLOW;

    // 0 = always ready, 1 = stalled, 2 = random 25% stall
    int   tx_mode = 1;
    logic rnd_stall = 1'b0;
    assign TX_DST_RDY_N = (tx_mode == 2) ? rnd_stall : (tx_mode == 1);

    always @(posedge clk) begin
        #1;
        rnd_stall = ($urandom_range(0, 3) == 0);
    end

    fl_slr_rx_buffer #(
        .DATA_WIDTH (DW),
        .DREM_WIDTH (RW),
        .LATENCY    (LAT),
        .DEPTH      (DEP),
        .USE_OUTREG (1)
    ) dut (
        .CLK          (clk),
        .RESET_N      (RESET_N),
        .RX_DATA      (RX_DATA),
        .RX_REM       (RX_REM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SOP_N     (RX_SOP_N),
        .RX_EOP_N     (RX_EOP_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .TX_DATA      (TX_DATA),
        .TX_REM       (TX_REM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SOP_N     (TX_SOP_N),
        .TX_EOP_N     (TX_EOP_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N),
        .OVERFLOW     (OVERFLOW)
    );

    logic [W-1:0] tx_word;
    assign tx_word = {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_REM, TX_DATA};

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         sb_en = 1'b0;
    int           rx_cnt = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;

    // Inputs change 1 time unit after posedge, so a transfer seen at the
    // falling edge is the one that happens at the next rising edge.
    always @(negedge clk) begin
        if (sb_en && RESET_N && !TX_SRC_RDY_N && !TX_DST_RDY_N) begin
            check_eq("sb_expected_word", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                check_eq("sb_word", tx_word, exp_q.pop_front());
            end
            rx_cnt++;
            if (rx_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    logic rdy_sh0 = 1'b1;
    logic rdy_sh1 = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
        // upstream sees ready through a LATENCY-deep pipe
        rdy_sh1 = rdy_sh0;
        rdy_sh0 = RX_DST_RDY_N;
    endtask

    task automatic drive_word(input logic [W-1:0] w);
        {RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_REM, RX_DATA} = w;
        RX_SRC_RDY_N = 1'b0;
    endtask

    task automatic idle_rx();
        RX_SRC_RDY_N = 1'b1;
    endtask

    task automatic send_gated(input logic [W-1:0] w);
        int guard;
        guard = 0;
        while (rdy_sh1 == 1'b1) begin
            idle_rx();
            step();
            guard++;
            if (guard > 1000) begin
                check_eq("src_ready_timeout", W'(rdy_sh1), W'(0));
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "FAIL source starved of ready");
            end
        end
        drive_word(w);
        exp_q.push_back(w);
        step();
        idle_rx();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        check_eq("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [W-1:0] mk_word(input int i);
        logic [31:0] iv;
        logic [63:0] d;
        iv = i;
        d  = 64'hC0DE_0000_0000_0000 | 64'(iv);
        return {iv[3], iv[2], iv[1], iv[0], iv[6:4], d};
    endfunction

    task automatic send_frame();
        fl_word_t fw;
        int bytes, nw;
        for (int p = 0; p < 2; p++) begin
            bytes = $urandom_range(8, 32);
            nw = (bytes + 7) / 8;
            for (int j = 0; j < nw; j++) begin
                fw.sof_n = !(p == 0 && j == 0);
                fw.eof_n = !(p == 1 && j == nw - 1);
                fw.sop_n = !(j == 0);
                fw.eop_n = !(j == nw - 1);
                fw.rem   = (j == nw - 1) ? 3'((bytes - 1) % 8) : 3'd7;
                fw.data  = {$urandom, $urandom};
                send_gated(fw);
            end
        end
    endtask

    // watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] w0;
        int n;
        logic rose;

        idle_rx();
        {RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_REM, RX_DATA} = '1;
        #1 RESET_N = 1'b0;

        // reset held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("rst_tx_src_rdy_n", W'(TX_SRC_RDY_N), W'(1));
            check_eq("rst_rx_dst_rdy_n", W'(RX_DST_RDY_N), W'(1));
        end
        check_eq("rst_overflow", W'(OVERFLOW), W'(0));
        check_eq("rst_tx_word", tx_word, W'(0));
        RESET_N = 1'b1;
        step();
        check_eq("rdy_after_release", W'(RX_DST_RDY_N), W'(0));

        // single-word frame latency through output register
        tx_mode = 0;
        w0 = {4'b0000, 3'd7, 64'h0123_4567_89AB_CDEF};
        drive_word(w0);
        step();                      // edge n: written
        idle_rx();
        check_eq("lat_n0_vld", W'(TX_SRC_RDY_N), W'(1));
        step();                      // edge n+1
        check_eq("lat_n1_vld", W'(TX_SRC_RDY_N), W'(1));
        step();                      // edge n+2
        check_eq("lat_n2_vld", W'(TX_SRC_RDY_N), W'(0));
        check_eq("lat_n2_word", tx_word, w0);
        step();                      // edge n+3: taken
        check_eq("lat_n3_vld", W'(TX_SRC_RDY_N), W'(1));

        // fill with TX stalled: ready drops once 3 words sit in memory
        // (5 written, 2 held in read stage + output register)
        tx_mode = 1;
        n = 0;
        rose = 1'b0;
        while (!rose && n < 20) begin
            drive_word(mk_word(n));
            step();
            n++;
            if (RX_DST_RDY_N) rose = 1'b1;
        end
        check_eq("rdy_rise_after_words", W'(n), W'(5));
        // worst-case compliant upstream: 2*LATENCY+1 more words in flight
        for (int i = 0; i < 2 * LAT + 1; i++) begin
            drive_word(mk_word(n));
            step();
            n++;
        end
        idle_rx();
        check_eq("full_no_overflow", W'(OVERFLOW), W'(0));
        check_eq("full_rdy_n", W'(RX_DST_RDY_N), W'(1));

        // one extra forced write into a full buffer
        drive_word(mk_word(99));
        step();
        idle_rx();
        check_eq("ovf_set", W'(OVERFLOW), W'(1));
        step();
        check_eq("ovf_sticky", W'(OVERFLOW), W'(1));
        check_eq("stall_hold_word", tx_word, mk_word(0));

        // drain: all accepted words in order, one per cycle, none extra
        tx_mode = 0;
        for (int i = 0; i < n; i++) begin
            check_eq("drain_vld", W'(TX_SRC_RDY_N), W'(0));
            check_eq("drain_word", tx_word, mk_word(i));
            step();
        end
        check_eq("drain_done_vld", W'(TX_SRC_RDY_N), W'(1));
        check_eq("drain_ovf_sticky", W'(OVERFLOW), W'(1));
        check_eq("drain_rdy_back", W'(RX_DST_RDY_N), W'(0));

        // reset in the middle of a frame with 5 words buffered
        tx_mode = 1;
        for (int i = 0; i < 5; i++) begin
            drive_word(mk_word(40 + i) | {1'b1, 1'b1, {(W-2){1'b0}}});
            step();
        end
        idle_rx();
        RESET_N = 1'b0;
        #1;
        check_eq("mid_rst_tx_vld", W'(TX_SRC_RDY_N), W'(1));
        check_eq("mid_rst_rdy_n", W'(RX_DST_RDY_N), W'(1));
        check_eq("mid_rst_ovf", W'(OVERFLOW), W'(0));
        check_eq("mid_rst_tx_word", tx_word, W'(0));
        step();
        check_eq("mid_rst_cyc_tx_vld", W'(TX_SRC_RDY_N), W'(1));
        RESET_N = 1'b1;
        step();
        check_eq("post_rst_rdy", W'(RX_DST_RDY_N), W'(0));
        tx_mode = 0;
        step();
        step();
        check_eq("post_rst_no_stale", W'(TX_SRC_RDY_N), W'(1));

        sb_en = 1'b1;
        rdy_sh0 = RX_DST_RDY_N;
        rdy_sh1 = RX_DST_RDY_N;
        rx_cnt = 0;
        send_gated(mk_word(70) & ~{1'b1, {(W-1){1'b0}}});
        send_gated(mk_word(71));
        send_gated(mk_word(72));
        wait_drain(50);
        check_eq("post_rst_frame_cnt", W'(rx_cnt), W'(3));

        // throughput: TX never stalls, 40 back-to-back words
        rx_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            send_gated({4'b1111, 3'(i), {$urandom, $urandom}});
        end
        wait_drain(50);
        check_eq("tput_cnt", W'(rx_cnt), W'(40));
        check_eq("tput_span", W'(last_cyc - first_cyc), W'(39));

        // random stalls, 2-part frames, scoreboard checks every word
        tx_mode = 2;
        rx_cnt = 0;
        n = 0;
        for (int f = 0; f < 2000; f++) begin
            send_frame();
        end
        tx_mode = 0;
        wait_drain(200);
        check_eq("rand_no_overflow", W'(OVERFLOW), W'(0));
        check_eq("rand_tail_idle", W'(TX_SRC_RDY_N), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
